// File: rtl/vend_if.sv
// Vending controller customer/machine interface.
// Groups the front-panel pulses (coin insertion, product selection, cancel,
// tray acknowledge) and the machine's registered status outputs.
//   master : customer side (drives pulses, observes indicators)
//   slave  : controller side (vend_ctrl)
// Money values are in half-yuan units, SUM_W bits wide.
interface vend_if #(
    parameter int unsigned N_ITEMS = 4,
    parameter int unsigned SUM_W   = 6
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    // customer -> controller
    logic               insert;
    logic [1:0]         coin_val;
    logic [SEL_W-1:0]   sel;
    logic               buy;
    logic               cancel;
    logic               take_ack;

    // controller -> customer
    logic               hold_ind;
    logic [N_ITEMS-1:0] avail;
    logic               drinktk_ind;
    logic [SEL_W-1:0]   item_out;
    logic               charge_ind;
    logic [SUM_W-1:0]   coin_sum;
    logic               coin_reject;
    logic               buy_err;

    modport master (
        output insert, coin_val, sel, buy, cancel, take_ack,
        input  hold_ind, avail, drinktk_ind, item_out, charge_ind,
               coin_sum, coin_reject, buy_err
    );

    modport slave (
        input  insert, coin_val, sel, buy, cancel, take_ack,
        output hold_ind, avail, drinktk_ind, item_out, charge_ind,
               coin_sum, coin_reject, buy_err
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller.
// Collects coins into a credit, vends a selected product when the credit
// covers its price, then returns any remaining change. An idle timeout while
// collecting refunds the credit automatically.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : vend_if.slave -- insert/coin_val/sel/buy/cancel/take_ack in;
//          hold_ind/avail/drinktk_ind/item_out/charge_ind/coin_sum/
//          coin_reject/buy_err out. All outputs are registered.
// Money is in half-yuan units (value = yuan*2).
module vend_ctrl #(
    parameter int unsigned               N_ITEMS   = 4,
    parameter int unsigned               SUM_W     = 6,
    parameter int unsigned               SUM_MAX   = 40,
    parameter logic [N_ITEMS*SUM_W-1:0]  PRICES    = {6'd20, 6'd10, 6'd5, 6'd3},
    parameter logic [4*SUM_W-1:0]        COIN_VALS = {6'd20, 6'd10, 6'd2, 6'd1},
    parameter int unsigned               TIMEOUT   = 1000
) (
    input  logic  clk,
    input  logic  rst,
    vend_if.slave bus
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q,   sum_d;
    logic [SEL_W-1:0]   item_q,  item_d;
    logic [TO_W-1:0]    cnt_q,   cnt_d;
    logic [N_ITEMS-1:0] avail_q, avail_d;
    logic               rej_q,   rej_d;
    logic               berr_q,  berr_d;
    logic               hold_q, drink_q, charge_q;

    logic [SUM_W-1:0]   coin_value;
    logic [SUM_W-1:0]   price;
    logic               sel_ok;
    logic [SUM_W:0]     sum_ext;
    logic               coin_fits;

    // Table lookups. sel_ok guards against indices beyond N_ITEMS when
    // N_ITEMS is not a power of two.
    always_comb begin
        coin_value = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.coin_val == 2'(i))
                coin_value = COIN_VALS[i*SUM_W +: SUM_W];
        end

        price  = '0;
        sel_ok = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                price  = PRICES[i*SUM_W +: SUM_W];
                sel_ok = 1'b1;
            end
        end

        // One extra bit so the cap comparison never sees a wrapped sum.
        sum_ext   = {1'b0, sum_q} + {1'b0, coin_value};
        coin_fits = (sum_ext <= (SUM_W+1)'(SUM_MAX));
    end

    // Next-state and next-output logic. Outputs are computed from the next
    // state so that registering them keeps them aligned with state_q.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        item_d  = item_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        berr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.insert) begin
                    sum_d   = coin_value;
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
                berr_d = bus.buy;
            end

            S_COLLECT: begin
                // cancel > buy > insert; a coin that loses arbitration is returned.
                if (bus.cancel) begin
                    state_d = S_CHANGE;
                    rej_d   = bus.insert;
                end else if (bus.buy) begin
                    cnt_d = '0;
                    rej_d = bus.insert;
                    if (sel_ok && (price <= sum_q)) begin
                        sum_d   = sum_q - price;
                        item_d  = bus.sel;
                        state_d = S_VEND;
                    end else begin
                        berr_d = 1'b1;
                    end
                end else if (bus.insert) begin
                    cnt_d = '0;
                    if (coin_fits)
                        sum_d = sum_ext[SUM_W-1:0];
                    else
                        rej_d = 1'b1;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_CHANGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_VEND: begin
                rej_d  = bus.insert;
                berr_d = bus.buy;
                if (bus.take_ack)
                    state_d = (sum_q != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                rej_d  = bus.insert;
                berr_d = bus.buy;
                if (bus.take_ack) begin
                    sum_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        for (int unsigned i = 0; i < N_ITEMS; i++)
            avail_d[i] = (state_d == S_COLLECT) && (sum_d >= PRICES[i*SUM_W +: SUM_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            item_q   <= '0;
            cnt_q    <= '0;
            avail_q  <= '0;
            rej_q    <= 1'b0;
            berr_q   <= 1'b0;
            hold_q   <= 1'b0;
            drink_q  <= 1'b0;
            charge_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            item_q   <= item_d;
            cnt_q    <= cnt_d;
            avail_q  <= avail_d;
            rej_q    <= rej_d;
            berr_q   <= berr_d;
            hold_q   <= (state_d != S_IDLE);
            drink_q  <= (state_d == S_VEND);
            charge_q <= (state_d == S_CHANGE);
        end
    end

    assign bus.hold_ind    = hold_q;
    assign bus.avail       = avail_q;
    assign bus.drinktk_ind = drink_q;
    assign bus.item_out    = item_q;
    assign bus.charge_ind  = charge_q;
    assign bus.coin_sum    = sum_q;
    assign bus.coin_reject = rej_q;
    assign bus.buy_err     = berr_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl (TIMEOUT overridden to 8).
// Default tables: prices item0..3 = 3,5,10,20; coin codes 0..3 = 1,2,10,20.
module tb_vend_ctrl;
    localparam int ST_IDLE = 0;
    localparam int ST_COL  = 1;
    localparam int ST_VND  = 2;
    localparam int ST_CHG  = 3;

    typedef struct packed {
        logic       hold;
        logic [3:0] avail;
        logic       drink;
        logic [1:0] item;
        logic       charge;
        logic [5:0] sum;
        logic       rej;
        logic       berr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    vend_if #(.N_ITEMS(4), .SUM_W(6)) bus ();

    vend_ctrl #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int st, input logic [3:0] av, input logic [1:0] it,
                                input logic [5:0] sm, input logic rj, input logic be);
        exp_t e;
        e.hold   = (st != ST_IDLE);
        e.drink  = (st == ST_VND);
        e.charge = (st == ST_CHG);
        e.avail  = av;
        e.item   = it;
        e.sum    = sm;
        e.rej    = rj;
        e.berr   = be;
        return e;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
            $error("%s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic check_front();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "hold_ind",    8'(bus.hold_ind),    8'(e.hold));
        cmp(t, "avail",       8'(bus.avail),       8'(e.avail));
        cmp(t, "drinktk_ind", 8'(bus.drinktk_ind), 8'(e.drink));
        cmp(t, "item_out",    8'(bus.item_out),    8'(e.item));
        cmp(t, "charge_ind",  8'(bus.charge_ind),  8'(e.charge));
        cmp(t, "coin_sum",    8'(bus.coin_sum),    8'(e.sum));
        cmp(t, "coin_reject", 8'(bus.coin_reject), 8'(e.rej));
        cmp(t, "buy_err",     8'(bus.buy_err),     8'(e.berr));
    endtask

    // Drive one cycle of pulses, then check the response the cycle after.
    task automatic step(input string tag, input logic ins, input logic [1:0] cv,
                        input logic b, input logic [1:0] s, input logic c,
                        input logic ta, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus.insert   = ins;
        bus.coin_val = cv;
        bus.buy      = b;
        bus.sel      = s;
        bus.cancel   = c;
        bus.take_ack = ta;
        @(posedge clk);
        #1;
        bus.insert   = 1'b0;
        bus.coin_val = 2'd0;
        bus.buy      = 1'b0;
        bus.sel      = 2'd0;
        bus.cancel   = 1'b0;
        bus.take_ack = 1'b0;
        check_front();
    endtask

    task automatic idle(input string tag, input exp_t e);
        step(tag, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, e);
    endtask
    task automatic ins(input string tag, input logic [1:0] cv, input exp_t e);
        step(tag, 1'b1, cv, 1'b0, 2'd0, 1'b0, 1'b0, e);
    endtask
    task automatic buy(input string tag, input logic [1:0] s, input exp_t e);
        step(tag, 1'b0, 2'd0, 1'b1, s, 1'b0, 1'b0, e);
    endtask
    task automatic ack(input string tag, input exp_t e);
        step(tag, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, e);
    endtask

    initial begin
        bus.insert   = 1'b0;
        bus.coin_val = 2'd0;
        bus.buy      = 1'b0;
        bus.sel      = 2'd0;
        bus.cancel   = 1'b0;
        bus.take_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(ST_IDLE, 4'b0000, 2'd0, 6'd0, 1'b0, 1'b0));
        tag_q.push_back("reset");
        check_front();
        rst = 1'b0;

        // Idle buy is refused; coins accumulate 2,4,5 half-yuan.
        buy("idle_buy", 2'd1,  mk(ST_IDLE, 4'b0000, 2'd0, 6'd0, 1'b0, 1'b1));
        ins("coin_a", 2'd1,    mk(ST_COL,  4'b0000, 2'd0, 6'd2, 1'b0, 1'b0));
        ins("coin_b", 2'd1,    mk(ST_COL,  4'b0001, 2'd0, 6'd4, 1'b0, 1'b0));
        ins("coin_c", 2'd0,    mk(ST_COL,  4'b0011, 2'd0, 6'd5, 1'b0, 1'b0));

        // Item 2 costs 10: refused at 5, sold at 15 with 5 change.
        buy("buy_short", 2'd2, mk(ST_COL,  4'b0011, 2'd0, 6'd5,  1'b0, 1'b1));
        ins("coin_d", 2'd2,    mk(ST_COL,  4'b0111, 2'd0, 6'd15, 1'b0, 1'b0));
        buy("buy_ok", 2'd2,    mk(ST_VND,  4'b0000, 2'd2, 6'd5,  1'b0, 1'b0));
        ins("vend_coin", 2'd3, mk(ST_VND,  4'b0000, 2'd2, 6'd5,  1'b1, 1'b0));
        step("vend_cancel", 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0,
                               mk(ST_VND,  4'b0000, 2'd2, 6'd5,  1'b0, 1'b0));
        ack("vend_ack", mk(ST_CHG,  4'b0000, 2'd2, 6'd5, 1'b0, 1'b0));
        ack("chg_ack",  mk(ST_IDLE, 4'b0000, 2'd2, 6'd0, 1'b0, 1'b0));

        // Exact price: no change, tray ack returns straight to IDLE.
        ins("exact_coin", 2'd2, mk(ST_COL,  4'b0111, 2'd2, 6'd10, 1'b0, 1'b0));
        buy("exact_buy", 2'd2,  mk(ST_VND,  4'b0000, 2'd2, 6'd0,  1'b0, 1'b0));
        ack("exact_ack",        mk(ST_IDLE, 4'b0000, 2'd2, 6'd0,  1'b0, 1'b0));

        // Credit cap: 20+10+10 = 40 accepted, next coin rejected.
        ins("cap_a", 2'd3, mk(ST_COL, 4'b1111, 2'd2, 6'd20, 1'b0, 1'b0));
        ins("cap_b", 2'd2, mk(ST_COL, 4'b1111, 2'd2, 6'd30, 1'b0, 1'b0));
        ins("cap_c", 2'd2, mk(ST_COL, 4'b1111, 2'd2, 6'd40, 1'b0, 1'b0));
        ins("cap_rej", 2'd0, mk(ST_COL, 4'b1111, 2'd2, 6'd40, 1'b1, 1'b0));
        step("cap_cancel", 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0,
                           mk(ST_CHG, 4'b0000, 2'd2, 6'd40, 1'b0, 1'b0));
        buy("chg_buy", 2'd0, mk(ST_CHG,  4'b0000, 2'd2, 6'd40, 1'b0, 1'b1));
        ack("cap_ack",       mk(ST_IDLE, 4'b0000, 2'd2, 6'd0,  1'b0, 1'b0));

        // Same-cycle insert+cancel+buy: cancel wins, coin returned, no buy_err.
        ins("prio_coin", 2'd2, mk(ST_COL, 4'b0111, 2'd2, 6'd10, 1'b0, 1'b0));
        step("prio_all", 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 1'b0,
                         mk(ST_CHG, 4'b0000, 2'd2, 6'd10, 1'b1, 1'b0));
        ack("prio_ack", mk(ST_IDLE, 4'b0000, 2'd2, 6'd0, 1'b0, 1'b0));

        // Timeout: 7 idle cycles stay in COLLECT, the 8th refunds.
        ins("to_coin", 2'd1, mk(ST_COL, 4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            idle("to_wait", mk(ST_COL, 4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        idle("to_fire", mk(ST_CHG,  4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        ack("to_ack",   mk(ST_IDLE, 4'b0000, 2'd2, 6'd0, 1'b0, 1'b0));

        // A coin mid-wait restarts the timeout count.
        ins("tr_coin", 2'd0, mk(ST_COL, 4'b0000, 2'd2, 6'd1, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            idle("tr_wait_a", mk(ST_COL, 4'b0000, 2'd2, 6'd1, 1'b0, 1'b0));
        ins("tr_coin2", 2'd0, mk(ST_COL, 4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            idle("tr_wait_b", mk(ST_COL, 4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        idle("tr_fire", mk(ST_CHG,  4'b0000, 2'd2, 6'd2, 1'b0, 1'b0));
        ack("tr_ack",   mk(ST_IDLE, 4'b0000, 2'd2, 6'd0, 1'b0, 1'b0));

        // Asynchronous reset in VEND with credit still held.
        ins("rv_a", 2'd3, mk(ST_COL, 4'b1111, 2'd2, 6'd20, 1'b0, 1'b0));
        ins("rv_b", 2'd2, mk(ST_COL, 4'b1111, 2'd2, 6'd30, 1'b0, 1'b0));
        buy("rv_buy", 2'd3, mk(ST_VND, 4'b0000, 2'd3, 6'd10, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(ST_IDLE, 4'b0000, 2'd0, 6'd0, 1'b0, 1'b0));
        tag_q.push_back("rst_async");
        check_front();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("rst_release", mk(ST_IDLE, 4'b0000, 2'd0, 6'd0, 1'b0, 1'b0));
        ins("post_rst", 2'd3, mk(ST_COL, 4'b1111, 2'd0, 6'd20, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
